// File: rtl/pll_rst_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.

package pll_rst_ctrl_pkg;

  typedef enum logic [2:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

  // Width of the shared down-counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned pulse_cyc,
                                            input int unsigned timeout_cyc,
                                            input int unsigned stable_cyc);
    int unsigned m;
    m = pulse_cyc;
    if (timeout_cyc > m) m = timeout_cyc;
    if (stable_cyc > m) m = stable_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int unsigned retry_width(input int unsigned max_retry);
    return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.

module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, supervises lock with timeout and
// bounded retries, and releases the system reset once lock has been stable.

module pll_rst_ctrl
  import pll_rst_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              relock_req_i,
  input  logic                              pll_locked_i,
  output logic                              pll_rst_o,
  output logic                              sys_rstn_o,
  output logic                              locked_o,
  output logic                              fail_o,
  output logic [retry_width(MAX_RETRY)-1:0] retry_cnt_o
);

  localparam int unsigned CntW   = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam int unsigned RetryW = retry_width(MAX_RETRY);

  localparam logic [CntW-1:0]   PulseLoad   = CntW'(RST_PULSE_CYC - 1);
  localparam logic [CntW-1:0]   TimeoutLoad = CntW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0]   StableLoad  = CntW'(LOCK_STABLE_CYC - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              pll_rst_q, pll_rst_d;
  logic              sys_rstn_q, sys_rstn_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;
  logic              lock_s;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  function automatic logic [CntW-1:0] cnt_load(input state_e s);
    case (s)
      StResetPll: return PulseLoad;
      StWaitLock: return TimeoutLoad;
      StStable:   return StableLoad;
      default:    return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;

    case (state_q)
      StResetPll: begin
        if (cnt_q == '0) state_d = StWaitLock;
      end
      StWaitLock: begin
        // Lock takes priority over a timeout expiring on the same cycle.
        if (lock_s) begin
          state_d = StStable;
        end else if (cnt_q == '0) begin
          if (retry_q == RetryMax) begin
            state_d = StFail;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = StResetPll;
          end
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == '0) begin
          state_d = StRun;
          retry_d = '0;
        end
      end
      StRun: begin
        if (!lock_s || relock_req_i) state_d = StResetPll;
      end
      StFail: begin
        if (relock_req_i) begin
          retry_d = '0;
          state_d = StResetPll;
        end
      end
      default: state_d = StResetPll;
    endcase

    // Every transition changes state, so each state entry starts a fresh count.
    if (state_d != state_q) cnt_d = cnt_load(state_d);

    pll_rst_d  = (state_d == StResetPll);
    sys_rstn_d = (state_d == StRun);
    locked_d   = (state_d == StRun);
    fail_d     = (state_d == StFail);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StResetPll;
      cnt_q      <= PulseLoad;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      sys_rstn_q <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_rst_q  <= pll_rst_d;
      sys_rstn_q <= sys_rstn_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rstn_o  = sys_rstn_q;
  assign locked_o    = locked_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scoreboard bench for pll_rst_ctrl: expected output-change events (cycle and
// value) are derived from the timing rules and matched by a change monitor.

module tb_pll_rst_ctrl;

  logic       clk;
  logic       rstn;
  logic       relock;
  logic       lock;
  logic       pll_rst;
  logic       sys_rstn;
  logic       locked;
  logic       fail;
  logic [1:0] retry;

  pll_rst_ctrl #(
    .RST_PULSE_CYC   (4),
    .LOCK_TIMEOUT_CYC(20),
    .LOCK_STABLE_CYC (8),
    .MAX_RETRY       (2),
    .SYNC_STAGES     (2)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .relock_req_i(relock),
    .pll_locked_i(lock),
    .pll_rst_o   (pll_rst),
    .sys_rstn_o  (sys_rstn),
    .locked_o    (locked),
    .fail_o      (fail),
    .retry_cnt_o (retry)
  );

  typedef struct {
    int         cyc;
    logic [5:0] val;
    string      name;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of rising edges seen so far.
  initial begin
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required run to finish earlier");
    $fatal(1);
  end

  function automatic logic [5:0] vec(input logic pr, input logic sr, input logic lk,
                                     input logic fl, input logic [1:0] rc);
    return {pr, sr, lk, fl, rc};
  endfunction

  function automatic logic [5:0] outs();
    return {pll_rst, sys_rstn, locked, fail, retry};
  endfunction

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [5:0] v, input string name);
    ev_t e;
    e.cyc  = c;
    e.val  = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected output changes never seen, required 0", name,
               exp_q.size());
      exp_q.delete();
    end
  endtask

  // Compares every observed output change against the head of the queue.
  task automatic monitor();
    logic [5:0] cur;
    logic [5:0] prev;
    ev_t        e;
    prev = vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    forever begin
      @(negedge clk);
      cur = outs();
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change: got %b at cycle %0d, required %b unchanged", cur,
                   cyc, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            miscompares++;
            $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d", e.name, cur,
                     cyc, e.val, e.cyc);
          end
        end
      end
      prev = cur;
    end
  endtask

  initial begin
    int r, k, k2, f, l, g;
    bit both;
    logic [5:0] idle, run;
    idle   = vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    run    = vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    rstn   = 1'b0;
    relock = 1'b0;
    lock   = 1'b0;
    fork
      monitor();
    join_none

    wait_to(2);
    check("reset_state", outs(), vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));

    // Clean start: 4-edge pulse, release 11 edges after lock rises.
    r = 3;
    wait_to(r);
    rstn = 1'b1;
    push(r + 4, idle, "pulse_end");
    k = r + int'($urandom_range(18, 2));
    wait_to(k);
    lock = 1'b1;
    push(k + 11, run, "clean_release");
    wait_to(k + 14);
    drain("clean_start");

    // Lock loss in RUN: reset 3 edges later, normal recovery.
    k = cyc + int'($urandom_range(6, 1));
    wait_to(k);
    lock = 1'b0;
    push(k + 3, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "loss_reset");
    push(k + 7, idle, "loss_wait");
    k2 = k + 5 + int'($urandom_range(10, 0));
    wait_to(k2);
    lock = 1'b1;
    push(k2 + 11, run, "loss_release");
    wait_to(k2 + 14);
    drain("lock_loss");

    // relock in RUN, sometimes coinciding with a lock drop.
    for (int i = 0; i < 3; i++) begin
      both = 1'($urandom_range(1, 0));
      k    = cyc + int'($urandom_range(5, 1));
      wait_to(k);
      relock = 1'b1;
      if (both) lock = 1'b0;
      push(k + 1, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "relock_reset");
      push(k + 5, idle, "relock_wait");
      wait_to(k + 1);
      relock = 1'b0;
      if (both) begin
        k2 = k + 5 + int'($urandom_range(10, 0));
        wait_to(k2);
        lock = 1'b1;
        push(k2 + 11, run, "relock_loss_release");
        wait_to(k2 + 14);
      end else begin
        push(k + 14, run, "relock_release");
        wait_to(k + 17);
      end
      drain("relock_run");
    end

    // Never locks: three pulses 24 cycles apart, then FAIL; relock ignored meanwhile.
    k = cyc + 2;
    wait_to(k);
    lock = 1'b0;
    push(k + 3, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "nl_reset0");
    push(k + 7, idle, "nl_wait0");
    push(k + 27, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd1), "nl_reset1");
    push(k + 31, vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd1), "nl_wait1");
    push(k + 51, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd2), "nl_reset2");
    push(k + 55, vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd2), "nl_wait2");
    push(k + 75, vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd2), "nl_fail");
    wait_to(k + 10);
    relock = 1'b1;
    wait_to(k + 11);
    relock = 1'b0;
    wait_to(k + 28);
    relock = 1'b1;
    wait_to(k + 29);
    relock = 1'b0;
    wait_to(k + 80);
    drain("never_lock");

    // relock in FAIL, one timeout, then a one-cycle glitch in STABLE with retry_cnt=1.
    f = cyc + int'($urandom_range(4, 1));
    wait_to(f);
    relock = 1'b1;
    push(f + 1, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "fail_relock");
    push(f + 5, idle, "fail_wait");
    push(f + 25, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd1), "fail_retry");
    push(f + 29, vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd1), "fail_retry_wait");
    wait_to(f + 1);
    relock = 1'b0;
    l = f + 28 + int'($urandom_range(8, 0));
    wait_to(l);
    lock = 1'b1;
    g = l + 1 + int'($urandom_range(7, 0));
    wait_to(g);
    lock = 1'b0;
    wait_to(g + 1);
    lock = 1'b1;
    push(g + 12, run, "glitch_release");
    wait_to(g + 15);
    drain("fail_glitch");

    // Async reset mid-STABLE; relock in STABLE beforehand is ignored.
    k = cyc + 2;
    wait_to(k);
    relock = 1'b1;
    push(k + 1, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "ar_relock");
    push(k + 5, idle, "ar_wait");
    wait_to(k + 1);
    relock = 1'b0;
    wait_to(k + 6);
    relock = 1'b1;
    wait_to(k + 7);
    relock = 1'b0;
    wait_to(k + 8);
    #2;
    push(k + 8, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "async_reset");
    rstn = 1'b0;
    #1;
    check("async_immediate", outs(), vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    r = k + 10;
    wait_to(r);
    rstn = 1'b1;
    push(r + 4, idle, "ar_pulse_end");
    push(r + 13, run, "ar_release");
    wait_to(r + 16);
    drain("async_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_rst_ctrl.md
# pll_rst_ctrl

Reset sequencer and lock supervisor for the system PLL: pulses the PLL reset, waits for lock with timeout and bounded retries, and releases the system reset only after lock has been stable. Runs on the free-running board reference clock (50 MHz), never on a PLL output. It sits between the board reset and the PLL, and drives the active-low reset of the NEORV32 system.

## Interface
- RST_PULSE_CYC, 16: PLL reset pulse length in clk_i cycles (≥1).
- LOCK_TIMEOUT_CYC, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- LOCK_STABLE_CYC, 1024: consecutive synchronized-locked cycles required before release (≥1).
- MAX_RETRY, 3: number of retries after the first attempt before FAIL (≥0).
- SYNC_STAGES, 2: synchronizer depth for pll_locked_i (≥2).
- clk_i  in  1  reference clock, free-running.
- rstn_i  in  1  asynchronous, active-low reset.
- relock_req_i  in  1  synchronous single-cycle request to restart the PLL sequence.
- pll_locked_i  in  1  PLL locked, asynchronous to clk_i.
- pll_rst_o  out  1  PLL reset, active-high.
- sys_rstn_o  out  1  system reset, active-low.
- locked_o  out  1  PLL locked and stable; the sequence has completed.
- fail_o  out  1  retries exhausted.
- retry_cnt_o  out  $clog2(MAX_RETRY+1)  retries used in the current sequence.

## Operation
- Lock input: pll_locked_i passes through SYNC_STAGES flops, giving lock_s. The FSM reads only lock_s.
- One down-counter (cnt) is shared by all states. It is reloaded on every state change.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL. Outputs are decoded from the registered state, so they are glitch-free.
- RESET_PLL:
  - pll_rst_o=1, sys_rstn_o=0.
  - After RST_PULSE_CYC cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst_o=0, sys_rstn_o=0.
  - If lock_s=1, go to STABLE.
  - Otherwise, after LOCK_TIMEOUT_CYC cycles:
    - if retry_cnt==MAX_RETRY, go to FAIL;
    - else increment retry_cnt and go to RESET_PLL.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK with a fresh timeout. No retry is consumed.
  - After LOCK_STABLE_CYC consecutive cycles with lock_s=1, go to RUN.
- RUN:
  - sys_rstn_o=1, locked_o=1, retry_cnt cleared.
  - If lock_s=0 or relock_req_i=1, go to RESET_PLL. Both together have the same effect.
- FAIL:
  - pll_rst_o=0, sys_rstn_o=0, fail_o=1.
  - relock_req_i clears retry_cnt and goes to RESET_PLL.
- relock_req_i is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- Reset values: state=RESET_PLL, cnt loaded for RST_PULSE_CYC, pll_rst_o=1, sys_rstn_o=0, locked_o=0, fail_o=0, retry_cnt_o=0, synchronizer flops=0.
- Reset asserted mid-sequence: all outputs take their reset values asynchronously; sys_rstn_o falls immediately.

## Timing
- Every FSM output is registered and changes on the clk_i edge at which the state changes.
- After rstn_i deasserts, pll_rst_o stays high for exactly RST_PULSE_CYC edges.
- pll_locked_i rise to sys_rstn_o rise, with stable lock: SYNC_STAGES + 1 + LOCK_STABLE_CYC edges.
- pll_locked_i fall in RUN to sys_rstn_o fall: SYNC_STAGES + 1 edges. pll_rst_o rises on the same edge.
- relock_req_i in RUN: sys_rstn_o falls and pll_rst_o rises on the next edge.
- Timeout: WAIT_LOCK lasts exactly LOCK_TIMEOUT_CYC cycles with lock_s=0.
- The sys_rstn_o deassertion is synchronous to clk_i only. Consumers in PLL-output domains must resynchronize it (assert async, release sync).
- Counter width: $clog2(max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC)). No wrap: the counter reloads on every state entry.

## Structure
- Package pll_rst_ctrl_pkg holds:
  - the state enum (3-bit, explicit encodings);
  - a function for the counter width.
- Sub-module sync_bit: SYNC_STAGES-deep flop chain, async active-low reset to 0. It is reused for the lock input here and by other CDC points.
- FSM, counter and retry counter live in pll_rst_ctrl.

## Test plan
Bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRY=2, SYNC_STAGES=2.
- Clean start: rstn_i released, pll_locked_i rises at cycle 10 → pll_rst_o high for 4 cycles; sys_rstn_o and locked_o rise 11 edges after the lock rise; retry_cnt_o=0.
- Never locks: pll_locked_i=0 → 3 RESET_PLL pulses 24 cycles apart; retry_cnt_o goes 1 then 2; fail_o=1 at cycle 72; sys_rstn_o stays 0.
- Lock glitch in STABLE: lock drops for 1 cycle after 5 stable cycles → back to WAIT_LOCK; release 11 edges after lock returns; retry_cnt_o unchanged.
- Lock loss in RUN: pll_locked_i falls → sys_rstn_o=0 and pll_rst_o=1 3 edges later; 4-cycle pulse; normal recovery.
- relock_req_i: in RUN → pll_rst_o=1 on the next edge; in FAIL → retry_cnt_o=0, fail_o=0, new sequence; in WAIT_LOCK → no effect.
- Async reset mid-STABLE: sys_rstn_o=0, pll_rst_o=1 and fail_o=0 immediately (no clock needed); sequence restarts on release.
